// File: rtl/cnn_settle_drain.sv
// Settle detector and snapshot drain for the 4x4 CNN array: compares successive frames,
// declares convergence or timeout, then streams the final 16 cell values over valid/ready.

module cnn_settle_lane #(
  parameter int WIDTH = 16,
  parameter int TOL   = 0
) (
  input  logic signed [WIDTH-1:0] cur,
  input  logic signed [WIDTH-1:0] prev,
  output logic                    match
);
  logic signed [WIDTH:0] diff;
  logic        [WIDTH:0] mag;

  // One extra bit keeps full-scale swings (e.g. -32768 -> 32767) from wrapping.
  always_comb begin
    diff  = {cur[WIDTH-1], cur} - {prev[WIDTH-1], prev};
    mag   = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    match = (32'(mag) <= $unsigned(32'(TOL)));
  end
endmodule

module cnn_settle_drain #(
  parameter int WIDTH         = 16,
  parameter int STABLE_FRAMES = 3,
  parameter int MAX_FRAMES    = 255,
  parameter int TOL           = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  frame_strobe,
  input  logic [16*WIDTH-1:0]   y_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [3:0]            out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic                  timeout,
  output logic [7:0]            iter_count
);
  localparam int NUM_LANES = 16;

  typedef enum logic [1:0] {IDLE, MONITOR, DRAIN} state_t;

  state_t                               state;
  // The latest frame is both the drain source and the compare reference for the next one.
  logic [NUM_LANES-1:0][WIDTH-1:0]      snap;
  logic [NUM_LANES-1:0]                 lane_match;
  logic [7:0]                           stable_cnt;
  logic                                 first;
  logic [3:0]                           idx;

  logic [7:0] iter_n, stable_n;
  logic       all_match, conv_hit, to_hit;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cnn_settle_lane #(.WIDTH(WIDTH), .TOL(TOL)) u_lane (
      .cur   (y_flat[g*WIDTH +: WIDTH]),
      .prev  (snap[g]),
      .match (lane_match[g])
    );
  end

  always_comb begin
    all_match = &lane_match;
    iter_n    = iter_count + 8'd1;
    if (first)          stable_n = stable_cnt;
    else if (all_match) stable_n = stable_cnt + 8'd1;
    else                stable_n = 8'd0;
    conv_hit  = (stable_n == 8'(STABLE_FRAMES));
    to_hit    = (iter_n == 8'(MAX_FRAMES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      snap       <= '0;
      stable_cnt <= '0;
      first      <= 1'b0;
      iter_count <= '0;
      converged  <= 1'b0;
      timeout    <= 1'b0;
      out_valid  <= 1'b0;
      idx        <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= MONITOR;
            iter_count <= '0;
            stable_cnt <= '0;
            converged  <= 1'b0;
            timeout    <= 1'b0;
            first      <= 1'b1;
          end
        end
        MONITOR: begin
          if (start) begin
            iter_count <= '0;
            stable_cnt <= '0;
            first      <= 1'b1;
          end else if (frame_strobe) begin
            snap       <= y_flat;
            iter_count <= iter_n;
            stable_cnt <= stable_n;
            first      <= 1'b0;
            if (conv_hit) begin
              converged <= 1'b1;
              state     <= DRAIN;
            end else if (to_hit) begin
              timeout <= 1'b1;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            idx       <= '0;
          end else if (out_ready) begin
            if (idx == 4'd15) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              done      <= 1'b1;
              idx       <= '0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_data = snap[idx];
  assign out_idx  = idx;
  assign out_last = (idx == 4'd15);
  assign busy     = (state != IDLE);
endmodule

// File: tb/tb_cnn_settle_drain.sv
// Directed bench for cnn_settle_drain (MAX_FRAMES=8, TOL=1) with a queue scoreboard of drain words.

module tb_cnn_settle_drain;
  localparam int W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              frame_strobe = 1'b0;
  logic [16*W-1:0]   y_flat = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_data;
  logic [3:0]        out_idx;
  logic              out_last;
  logic              busy, done, converged, timeout;
  logic [7:0]        iter_count;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  cnn_settle_drain #(.WIDTH(W), .STABLE_FRAMES(3), .MAX_FRAMES(8), .TOL(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_strobe(frame_strobe), .y_flat(y_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done), .converged(converged), .timeout(timeout),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16*W-1:0] fill(input int v);
    logic [16*W-1:0] r;
    for (int k = 0; k < 16; k++) r[k*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [16*W-1:0] ramp(input int base, input int step);
    logic [16*W-1:0] r;
    for (int k = 0; k < 16; k++) r[k*W +: W] = W'(base + k*step);
    return r;
  endfunction

  // even cells c+d, odd cells c-d
  function automatic logic [16*W-1:0] jit(input int c, input int d);
    logic [16*W-1:0] r;
    for (int k = 0; k < 16; k++) r[k*W +: W] = W'((k % 2 == 0) ? c + d : c - d);
    return r;
  endfunction

  // Drive one frame; the scoreboard always holds the latest accepted frame.
  task automatic strobe(input logic [16*W-1:0] f);
    y_flat = f;
    frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(f[k*W +: W]);
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Last frame of a run: check the decision and the one-cycle gap before out_valid.
  task automatic final_strobe(input logic [16*W-1:0] f, input string tag,
                              input logic cv, input logic to, input int it);
    y_flat = f;
    frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(f[k*W +: W]);
    chk({tag, "_conv"}, 32'(converged), 32'(cv));
    chk({tag, "_tmo"}, 32'(timeout), 32'(to));
    chk({tag, "_iter"}, 32'(iter_count), 32'(it));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_valid_gap"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid_up"}, 32'(out_valid), 32'd1);
  endtask

  // mode 0: ready always; mode 1: ready pattern 1,0,0 repeating
  task automatic drain(input string tag, input int mode);
    int n = 0;
    int cyc = 0;
    logic rdy;
    while (n < 16 && cyc < 200) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      out_ready = rdy;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_idx"}, 32'(out_idx), 32'(n));
      chk({tag, "_last"}, 32'(out_last), 32'(n == 15));
      if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      else chk({tag, "_data"}, 32'(out_data), 32'(exp_q[0]));
      chk({tag, "_no_done"}, 32'(done), 32'd0);
      if (out_valid && rdy) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        n++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk({tag, "_count"}, 32'(n), 32'd16);
    if (mode == 0) chk({tag, "_cycles"}, 32'(cyc), 32'd16);
    chk({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_valid_off"}, 32'(out_valid), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    // 1: reset values, then idle with stray strobes
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_iter", 32'(iter_count), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      y_flat = fill(i + 1);
      frame_strobe = (i % 2 == 0);
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
    end
    frame_strobe = 1'b0;
    chk("idle_iter", 32'(iter_count), 32'd0);
    chk("idle_flags", {out_valid, done, converged, timeout, out_last}, 32'd0);
    chk("idle_data", 32'(out_data), 32'd0);
    chk("idle_idx", 32'(out_idx), 32'd0);

    // 2: constant frames converge on the 4th strobe
    pulse_start();
    chk("t2_busy", 32'(busy), 32'd1);
    strobe(fill(5)); strobe(fill(5));
    strobe(fill(5));
    chk("t2_pre_conv", 32'(converged), 32'd0);
    final_strobe(fill(5), "t2", 1'b1, 1'b0, 4);
    drain("t2_drain", 0);
    repeat (3) tick();
    chk("t2_hold_conv", 32'(converged), 32'd1);
    chk("t2_hold_iter", 32'(iter_count), 32'd4);

    // 3: alternating 3/-3 never settles -> timeout at frame 8
    pulse_start();
    chk("t3_clear_conv", 32'(converged), 32'd0);
    chk("t3_clear_iter", 32'(iter_count), 32'd0);
    for (int f = 1; f <= 7; f++) strobe(fill((f % 2) ? 3 : -3));
    chk("t3_pre_tmo", 32'(timeout), 32'd0);
    final_strobe(fill(-3), "t3", 1'b0, 1'b1, 8);
    // start/strobe must be ignored while draining
    start = 1'b1; frame_strobe = 1'b1; y_flat = fill(77);
    tick();
    start = 1'b0; frame_strobe = 1'b0;
    chk("t3_drain_ign_iter", 32'(iter_count), 32'd8);
    chk("t3_drain_ign_tmo", 32'(timeout), 32'd1);
    drain("t3_drain", 0);

    // 4: distinct cell values drained with a stalling consumer
    pulse_start();
    strobe(ramp(-700, 100)); strobe(ramp(-700, 100)); strobe(ramp(-700, 100));
    final_strobe(ramp(-700, 100), "t4", 1'b1, 1'b0, 4);
    drain("t4_drain", 1);

    // 5a: +-1 jitter within TOL converges at frame 4
    pulse_start();
    strobe(jit(10, 0)); strobe(jit(10, 1)); strobe(jit(10, 0));
    final_strobe(jit(10, 1), "t5a", 1'b1, 1'b0, 4);
    drain("t5a_drain", 0);

    // 5b: a step of 2 on frame 3 resets the stable count -> converges at frame 6
    pulse_start();
    strobe(fill(0)); strobe(fill(1)); strobe(fill(3)); strobe(fill(2)); strobe(fill(3));
    chk("t5b_pre_conv", 32'(converged), 32'd0);
    chk("t5b_pre_busy", 32'(busy), 32'd1);
    final_strobe(fill(2), "t5b", 1'b1, 1'b0, 6);
    drain("t5b_drain", 0);

    // 5c: -32768 -> 32767 on one cell must not look like a 1-step change
    pulse_start();
    strobe(fill(-32768)); strobe(fill(-32768)); strobe(fill(-32768));
    strobe(fill(32767));
    chk("t5c_full_swing", 32'(converged), 32'd0);
    chk("t5c_still_busy", 32'(busy), 32'd1);
    strobe(fill(32767)); strobe(fill(32767));
    final_strobe(fill(32767), "t5c", 1'b1, 1'b0, 7);
    drain("t5c_drain", 0);

    // 5d: convergence and frame limit on the same strobe -> converged wins
    pulse_start();
    strobe(fill(0)); strobe(fill(5)); strobe(fill(0)); strobe(fill(5));
    strobe(fill(0)); strobe(fill(0)); strobe(fill(0));
    final_strobe(fill(0), "t5d", 1'b1, 1'b0, 8);
    drain("t5d_drain", 0);

    // 6: restart mid-run, start beats a simultaneous strobe, reset mid-drain
    pulse_start();
    strobe(fill(9)); strobe(fill(9)); strobe(fill(1));
    chk("t6_iter3", 32'(iter_count), 32'd3);
    pulse_start();
    chk("t6_restart_iter", 32'(iter_count), 32'd0);
    chk("t6_restart_busy", 32'(busy), 32'd1);
    start = 1'b1; frame_strobe = 1'b1; y_flat = fill(7);
    tick();
    start = 1'b0; frame_strobe = 1'b0;
    chk("t6_start_wins", 32'(iter_count), 32'd0);
    strobe(fill(7)); strobe(fill(7)); strobe(fill(7));
    final_strobe(fill(7), "t6", 1'b1, 1'b0, 4);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("t6_mid_idx", 32'(out_idx), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_conv", 32'(converged), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_rst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    tick(); tick();
    chk("t6_post_done", 32'(done), 32'd0);
    chk("t6_post_busy", 32'(busy), 32'd0);
    chk("t6_post_iter", 32'(iter_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
